// File: rtl/iir_hp_pkg.sv
// Shared types and width helpers for the time-shared IIR highpass scheduler.
package iir_hp_pkg;

   typedef enum logic {IDLE, RUN} state_t;

   typedef enum logic [1:0] {SAT_NONE, SAT_POS, SAT_NEG} sat_t;

   function automatic int sum_width(input int tdata_width, input int log2_alpha);
      return tdata_width + log2_alpha;
   endfunction

   function automatic int diff_width(input int tdata_width, input int log2_alpha);
      return sum_width(tdata_width, log2_alpha) + 1;
   endfunction

   // Top two bits of the difference decide whether the output lane saturates.
   function automatic sat_t sat_kind(input logic [1:0] top2);
      case (top2)
         2'b01:   return SAT_POS;
         2'b10:   return SAT_NEG;
         default: return SAT_NONE;
      endcase
   endfunction

endpackage

// File: rtl/iir_highpass_step.sv
// One combinational first-order highpass step: new integrator value and clipped output.
module iir_highpass_step
   import iir_hp_pkg::*;
#(
   parameter  int TDATA_WIDTH     = 16,
   parameter  int LOG2_ALPHA      = 10,
   parameter  int LOG2_ALPHA_FAST = 4,
   localparam int SW              = sum_width(TDATA_WIDTH, LOG2_ALPHA),
   localparam int DW              = diff_width(TDATA_WIDTH, LOG2_ALPHA)
) (
   input  logic signed [TDATA_WIDTH-1:0] sample,
   input  logic signed [SW-1:0]          sum,
   input  logic                          fast,
   output logic signed [SW-1:0]          next_sum,
   output logic signed [TDATA_WIDTH-1:0] y
);

   logic signed [DW-1:0] x;
   logic signed [DW-1:0] diff;
   logic signed [SW-1:0] delta;

   // The sample is scaled by alpha and carries one guard bit so the difference never wraps.
   assign x    = {{(DW - TDATA_WIDTH - LOG2_ALPHA){sample[TDATA_WIDTH-1]}}, sample, {LOG2_ALPHA{1'b0}}};
   assign diff = x - {sum[SW-1], sum};

   // NOTE: every output of a combinational block gets a value on every path, so no latch is inferred.
   always_comb begin
      delta = fast ? SW'(diff >>> LOG2_ALPHA_FAST) : SW'(diff >>> LOG2_ALPHA);
      next_sum = sum + delta;
      case (sat_kind(diff[DW-1 -: 2]))
         SAT_POS: y = {1'b0, {(TDATA_WIDTH-1){1'b1}}};
         SAT_NEG: y = {1'b1, {(TDATA_WIDTH-1){1'b0}}};
         default: y = diff[DW-2 -: TDATA_WIDTH];
      endcase
   end

endmodule

// File: rtl/iir_highpass_scheduler.sv
// Time-shares one IIR highpass step across NCHANNELS lanes, one lane per clock, and
// presents the filtered frame at once; channels fast-settle after reset or a clear.
module iir_highpass_scheduler
   import iir_hp_pkg::*;
#(
   parameter int NCHANNELS       = 8,
   parameter int TDATA_WIDTH     = 16,
   parameter int LOG2_ALPHA      = 10,
   parameter int LOG2_ALPHA_FAST = 4,
   parameter int SETTLE_SAMPLES  = 64
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NCHANNELS*TDATA_WIDTH-1:0] S_TDATA,
   input  logic                             S_TVALID,
   output logic [NCHANNELS*TDATA_WIDTH-1:0] M_TDATA,
   output logic                             M_TVALID,
   input  logic                             clear_stb,
   input  logic [NCHANNELS-1:0]             clear_mask,
   output logic [NCHANNELS-1:0]             settling,
   output logic                             busy,
   output logic                             overrun,
   input  logic                             overrun_clr
);

   localparam int SW   = sum_width(TDATA_WIDTH, LOG2_ALPHA);
   localparam int CHW  = $clog2(NCHANNELS);
   localparam int CNTW = $clog2(SETTLE_SAMPLES + 1);
   localparam logic [CHW-1:0]  LAST_CH     = CHW'(NCHANNELS - 1);
   localparam logic [CNTW-1:0] SETTLE_INIT = CNTW'(SETTLE_SAMPLES);

   state_t                           state, state_nxt;
   logic [CHW-1:0]                   ch, ch_nxt;
   logic                             accept, drop, last;
   logic [NCHANNELS*TDATA_WIDTH-1:0] frame_q;
   logic signed [SW-1:0]             sum_q [NCHANNELS];
   logic [CNTW-1:0]                  cnt_q [NCHANNELS];

   logic signed [TDATA_WIDTH-1:0]    lane_sample, lane_y;
   logic signed [SW-1:0]             lane_sum, lane_next_sum;
   logic                             lane_fast;

   always_comb begin
      state_nxt = state;
      ch_nxt    = ch;
      accept    = 1'b0;
      drop      = 1'b0;
      last      = 1'b0;
      case (state)
         IDLE: begin
            if (S_TVALID) begin
               accept    = 1'b1;
               ch_nxt    = '0;
               state_nxt = RUN;
            end
         end
         RUN: begin
            drop   = S_TVALID;
            ch_nxt = ch + 1'b1;
            if (ch == LAST_CH) begin
               last      = 1'b1;
               ch_nxt    = '0;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         ch    <= '0;
      end else begin
         state <= state_nxt;
         ch    <= ch_nxt;
      end
   end

   // NOTE: the captured frame is pure datapath and needs no reset; the integrator array below is
   // reset because reset must restart every channel's fast-settle from a zero integrator.
   always_ff @(posedge clk) begin
      if (accept) frame_q <= S_TDATA;
   end

   assign lane_sample = frame_q[ch*TDATA_WIDTH +: TDATA_WIDTH];
   assign lane_sum    = sum_q[ch];
   assign lane_fast   = (cnt_q[ch] != '0);

   iir_highpass_step #(
      .TDATA_WIDTH    (TDATA_WIDTH),
      .LOG2_ALPHA     (LOG2_ALPHA),
      .LOG2_ALPHA_FAST(LOG2_ALPHA_FAST)
   ) u_step (
      .sample  (lane_sample),
      .sum     (lane_sum),
      .fast    (lane_fast),
      .next_sum(lane_next_sum),
      .y       (lane_y)
   );

   // A clear wins over the same channel's update; that lane's output still uses the old state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < NCHANNELS; k++) begin
            sum_q[k] <= '0;
            cnt_q[k] <= SETTLE_INIT;
         end
      end else begin
         for (int k = 0; k < NCHANNELS; k++) begin
            if (clear_stb && clear_mask[k]) begin
               sum_q[k] <= '0;
               cnt_q[k] <= SETTLE_INIT;
            end else if (state == RUN && ch == CHW'(k)) begin
               sum_q[k] <= lane_next_sum;
               if (cnt_q[k] != '0) cnt_q[k] <= cnt_q[k] - 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         M_TDATA  <= '0;
         M_TVALID <= 1'b0;
         overrun  <= 1'b0;
      end else begin
         if (state == RUN) M_TDATA[ch*TDATA_WIDTH +: TDATA_WIDTH] <= lane_y;
         M_TVALID <= last;
         if (drop)             overrun <= 1'b1;
         else if (overrun_clr) overrun <= 1'b0;
      end
   end

   always_comb begin
      busy = (state == RUN);
      for (int k = 0; k < NCHANNELS; k++) settling[k] = (cnt_q[k] != '0);
   end

endmodule

// File: tb/tb_iir_highpass_scheduler.sv
// Self-checking bench for iir_highpass_scheduler: vector table, hand-written corner
// sequences and randomized frames against a plain-arithmetic reference model.
module tb_iir_highpass_scheduler;

   localparam int N   = 4;
   localparam int TW  = 16;
   localparam int LA  = 10;
   localparam int LAF = 4;
   localparam int SS  = 8;
   localparam int FW  = N * TW;
   localparam int SW  = TW + LA;
   localparam longint YMAX = (longint'(1) << (TW - 1)) - 1;
   localparam longint YMIN = -(longint'(1) << (TW - 1));

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [FW-1:0] S_TDATA = '0;
   logic          S_TVALID = 1'b0;
   logic [FW-1:0] M_TDATA;
   logic          M_TVALID;
   logic          clear_stb = 1'b0;
   logic [N-1:0]  clear_mask = '0;
   logic [N-1:0]  settling;
   logic          busy;
   logic          overrun;
   logic          overrun_clr = 1'b0;

   int tests = 0;
   int fails = 0;

   iir_highpass_scheduler #(
      .NCHANNELS(N), .TDATA_WIDTH(TW), .LOG2_ALPHA(LA),
      .LOG2_ALPHA_FAST(LAF), .SETTLE_SAMPLES(SS)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .S_TDATA(S_TDATA), .S_TVALID(S_TVALID),
      .M_TDATA(M_TDATA), .M_TVALID(M_TVALID),
      .clear_stb(clear_stb), .clear_mask(clear_mask),
      .settling(settling), .busy(busy),
      .overrun(overrun), .overrun_clr(overrun_clr)
   );

   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: simulation did not finish, tests=%0d fails=%0d", tests, fails);
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Reference model: ideal integrator per channel, floor-scaled output, saturated to TW bits.
   longint m_sum [N];
   int     m_cnt [N];

   function automatic longint wrap_sum(input longint v);
      longint w;
      w = v & ((longint'(1) << SW) - 1);
      if (w >= (longint'(1) << (SW - 1))) w -= (longint'(1) << SW);
      return w;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < N; k++) begin
         m_sum[k] = 0;
         m_cnt[k] = SS;
      end
   endtask

   task automatic model_clear(input logic [N-1:0] mask);
      for (int k = 0; k < N; k++) if (mask[k]) begin
         m_sum[k] = 0;
         m_cnt[k] = SS;
      end
   endtask

   task automatic model_frame(input logic [FW-1:0] din, output logic [FW-1:0] dout);
      for (int k = 0; k < N; k++) begin
         logic signed [TW-1:0] s;
         longint x, diff, yv;
         int sh;
         s    = din[k*TW +: TW];
         x    = longint'(s) * (longint'(1) << LA);
         diff = x - m_sum[k];
         yv   = diff >>> LA;
         if (yv > YMAX) yv = YMAX;
         if (yv < YMIN) yv = YMIN;
         sh = (m_cnt[k] != 0) ? LAF : LA;
         m_sum[k] = wrap_sum(m_sum[k] + (diff >>> sh));
         if (m_cnt[k] > 0) m_cnt[k]--;
         dout[k*TW +: TW] = yv[TW-1:0];
      end
   endtask

   function automatic logic [N-1:0] model_settling();
      logic [N-1:0] r;
      for (int k = 0; k < N; k++) r[k] = (m_cnt[k] != 0);
      return r;
   endfunction

   function automatic logic [FW-1:0] mk(input int l0, input int l1, input int l2, input int l3);
      return {TW'(l3), TW'(l2), TW'(l1), TW'(l0)};
   endfunction

   // All tasks start and end on a falling edge; inputs change there, outputs are sampled there.
   task automatic do_reset();
      S_TVALID = 1'b0; clear_stb = 1'b0; overrun_clr = 1'b0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // Offers one frame and waits for M_TVALID; clear_stb is raised at sample point clr_at
   // (point 0 is the falling edge just after the accepting edge).
   task automatic run_frame(input logic [FW-1:0] data, input int clr_at,
                            input logic [N-1:0] mask, output logic [FW-1:0] dout);
      bit done;
      done = 1'b0;
      dout = '0;
      S_TDATA = data;
      S_TVALID = 1'b1;
      clear_mask = mask;
      for (int i = 0; i < 3 * N && !done; i++) begin
         @(negedge clk);
         S_TVALID = 1'b0;
         clear_stb = (i == clr_at);
         if (M_TVALID) begin
            done = 1'b1;
            dout = M_TDATA;
         end
      end
      clear_stb = 1'b0;
      check("frame_done_in_time", done, 1'b1);
   endtask

   typedef struct {
      logic [FW-1:0] din;
      logic [FW-1:0] dout;
      logic [N-1:0]  settle;
   } vec_t;

   vec_t          step_tbl [5];
   logic [FW-1:0] lat_frames [3];
   logic [FW-1:0] out, exp, d;
   logic [14:0]   mv, bz;
   int            nf, cnt;
   shortint       ya, yb, v;

   initial begin
      step_tbl[0] = '{mk(1000, 0, 0, 0), mk(1000, 0, 0, 0), 4'hF};
      step_tbl[1] = '{mk(1000, 0, 0, 0), mk(937, 0, 0, 0), 4'hF};
      step_tbl[2] = '{mk(1000, 0, 0, 0), mk(878, 0, 0, 0), 4'hF};
      step_tbl[3] = '{mk(1000, 0, 0, 0), mk(823, 0, 0, 0), 4'hF};
      step_tbl[4] = '{mk(1000, 0, 0, 0), mk(772, 0, 0, 0), 4'hF};
      lat_frames[0] = mk(11, -22, 33, -44);
      lat_frames[1] = mk(500, 600, -700, 800);
      lat_frames[2] = mk(-1, 2, -3, 4);

      // Reset state
      do_reset();
      model_reset();
      check("reset_mtvalid", M_TVALID, 1'b0);
      check("reset_mtdata", M_TDATA, '0);
      check("reset_overrun", overrun, 1'b0);
      check("reset_busy", busy, 1'b0);
      check("reset_settling", settling, 4'hF);

      // Latency and spacing: accepts at points -1, 4, 9; a stray strobe at point 0 is dropped.
      mv = '0; bz = '0; nf = 0;
      for (int i = -1; i < 15; i++) begin
         if (i >= 0) begin
            mv[i] = M_TVALID;
            bz[i] = busy;
            if (M_TVALID && nf < 3) begin
               model_frame(lat_frames[nf], exp);
               check("lat_frame_data", M_TDATA, exp);
               nf++;
            end
         end
         S_TVALID = 1'b0;
         if (i == -1)     begin S_TVALID = 1'b1; S_TDATA = lat_frames[0]; end
         else if (i == 0) begin S_TVALID = 1'b1; S_TDATA = mk(9999, 9999, 9999, 9999); end
         else if (i == 4) begin S_TVALID = 1'b1; S_TDATA = lat_frames[1]; end
         else if (i == 9) begin S_TVALID = 1'b1; S_TDATA = lat_frames[2]; end
         @(negedge clk);
      end
      check("lat_mtvalid_pattern", mv, 15'h4210);
      check("lat_busy_pattern", bz, 15'h3DEF);
      check("lat_frame_count", nf, 3);
      check("overrun_set", overrun, 1'b1);
      overrun_clr = 1'b1;
      @(negedge clk);
      overrun_clr = 1'b0;
      check("overrun_cleared", overrun, 1'b0);
      S_TDATA = lat_frames[0]; S_TVALID = 1'b1;
      @(negedge clk);
      overrun_clr = 1'b1;
      @(negedge clk);
      S_TVALID = 1'b0; overrun_clr = 1'b0;
      check("overrun_set_wins", overrun, 1'b1);

      // Step response: table for the fast-settle frames, model afterwards
      do_reset();
      model_reset();
      for (int f = 0; f < 5; f++) begin
         run_frame(step_tbl[f].din, -1, '0, out);
         model_frame(step_tbl[f].din, exp);
         check("step_tbl_out", out, step_tbl[f].dout);
         check("step_tbl_settling", settling, step_tbl[f].settle);
      end
      ya = 0; yb = 0;
      for (int f = 5; f < 20; f++) begin
         run_frame(step_tbl[0].din, -1, '0, out);
         model_frame(step_tbl[0].din, exp);
         check("step_model", out, exp);
         check("step_settling", settling, (f < 7) ? 4'hF : 4'h0);
         if (f == 8) ya = out[TW-1:0];
         if (f == 9) yb = out[TW-1:0];
      end
      check("step_slow_decay", ((ya - yb) <= 1) && (yb > 0), 1'b1);

      // Clipping: lane1 parked at negative full scale then stepped up; lane2 mirrors it
      do_reset();
      model_reset();
      d = mk(0, -32768, 32767, 0);
      for (int f = 0; f < 40; f++) begin
         run_frame(d, -1, '0, out);
         model_frame(d, exp);
      end
      check("clip_settled_model", out, exp);
      d = mk(0, 32767, -32768, 0);
      run_frame(d, -1, '0, out);
      model_frame(d, exp);
      check("clip_pos_lane1", out[1*TW +: TW], 16'h7FFF);
      check("clip_neg_lane2", out[2*TW +: TW], 16'h8000);
      check("clip_model", out, exp);

      // Clear colliding with the RUN update of channel 2
      do_reset();
      model_reset();
      d = mk(100, -200, 3000, 500);
      for (int f = 0; f < 10; f++) begin
         run_frame(d, -1, '0, out);
         model_frame(d, exp);
         check("coll_pre_model", out, exp);
      end
      run_frame(d, 2, 4'b0100, out);
      model_frame(d, exp);
      model_clear(4'b0100);
      check("coll_frame_old_sum", out, exp);
      check("coll_settling", settling, 4'b0100);
      run_frame(d, -1, '0, out);
      model_frame(d, exp);
      check("coll_next_raw", out[2*TW +: TW], 16'd3000);
      check("coll_next_model", out, exp);
      for (int f = 0; f < 6; f++) begin
         run_frame(d, -1, '0, out);
         model_frame(d, exp);
      end
      check("coll_still_settling", settling, 4'b0100);
      run_frame(d, -1, '0, out);
      model_frame(d, exp);
      check("coll_settle_done", settling, 4'b0000);

      // Reset during RUN at channel 1, with overrun and output data nonzero beforehand
      do_reset();
      model_reset();
      d = mk(1234, -4321, 77, -8);
      run_frame(d, -1, '0, out);
      S_TDATA = d; S_TVALID = 1'b1;
      @(negedge clk);
      @(negedge clk);
      S_TVALID = 1'b0;
      check("midrst_overrun_before", overrun, 1'b1);
      rst_n = 1'b0;
      #1;
      check("midrst_mtdata", M_TDATA, '0);
      check("midrst_mtvalid", M_TVALID, 1'b0);
      check("midrst_overrun", overrun, 1'b0);
      check("midrst_busy", busy, 1'b0);
      check("midrst_settling", settling, 4'hF);
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      repeat (8) begin
         @(negedge clk);
         if (M_TVALID) cnt++;
      end
      check("midrst_no_mtvalid", cnt, 0);
      model_reset();
      run_frame(d, -1, '0, out);
      model_frame(d, exp);
      check("midrst_first_raw", out, d);
      check("midrst_first_model", out, exp);

      // Randomized frames with occasional idle-time clears
      do_reset();
      model_reset();
      for (int f = 0; f < 300; f++) begin
         if ($urandom_range(0, 7) == 0) begin
            logic [N-1:0] m;
            m = N'($urandom);
            clear_mask = m;
            clear_stb = 1'b1;
            @(negedge clk);
            clear_stb = 1'b0;
            model_clear(m);
         end
         for (int k = 0; k < N; k++) begin
            case ($urandom_range(0, 3))
               0:       d[k*TW +: TW] = 16'h7FFF;
               1:       d[k*TW +: TW] = 16'h8000;
               default: d[k*TW +: TW] = TW'($urandom);
            endcase
         end
         run_frame(d, -1, '0, out);
         model_frame(d, exp);
         check("rand_out", out, exp);
         check("rand_settling", settling, model_settling());
      end

      // DC rejection: the slow time constant is 1024 frames, so run several of them
      do_reset();
      model_reset();
      d = mk(-5000, -5000, -5000, -5000);
      for (int f = 0; f < 9000; f++) begin
         run_frame(d, -1, '0, out);
         model_frame(d, exp);
         if (f == 2999) check("dc_model_3000", out, exp);
      end
      check("dc_model_end", out, exp);
      for (int k = 0; k < N; k++) begin
         v = out[k*TW +: TW];
         check("dc_lane_magnitude", (v >= -1) && (v <= 1), 1'b1);
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
